// File: rtl/cpu_tt_pkg.sv
// Shared encodings for the Tiny Tapeout CPU loader: pin commands, loader FSM states,
// sticky error bit positions and a small byte-index helper.
package cpu_tt_pkg;

    typedef enum logic [1:0] {
        CMD_SET_ADDR = 2'b00,
        CMD_WRITE    = 2'b01,
        CMD_READ     = 2'b10,
        CMD_CTRL     = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMMIT  = 2'b01,
        RD_WAIT = 2'b10,
        RD_CAP  = 2'b11
    } state_t;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_RUNNING = 1;
    localparam int ERR_TYPE    = 2;

    localparam int MAX_BYTES = 4;

    // Index of the final byte of an n-byte word (n is 1..4).
    function automatic logic [1:0] last_idx(input int n);
        return 2'(n - 1);
    endfunction

endpackage

// File: rtl/cpu_load_ctrl_if.sv
// Memory-side port bundle between the loader (master) and the CPU memories (slave).
interface cpu_load_ctrl_if #(
    parameter int ADDR_W      = 5,
    parameter int INSTR_BYTES = 2,
    parameter int DATA_BYTES  = 1
);
    // imem_we/dmem_we/mem_re are single-cycle pulses qualified by mem_addr and the
    // write data in the same cycle; read data is valid one cycle after mem_re.
    logic                     imem_we;
    logic [INSTR_BYTES*8-1:0] imem_wdata;
    logic                     dmem_we;
    logic [DATA_BYTES*8-1:0]  dmem_wdata;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_re;
    logic                     mem_re_instr;
    logic [INSTR_BYTES*8-1:0] imem_rdata;
    logic [DATA_BYTES*8-1:0]  dmem_rdata;

    modport master (
        output imem_we, imem_wdata, dmem_we, dmem_wdata, mem_addr, mem_re, mem_re_instr,
        input  imem_rdata, dmem_rdata
    );

    modport slave (
        input  imem_we, imem_wdata, dmem_we, dmem_wdata, mem_addr, mem_re, mem_re_instr,
        output imem_rdata, dmem_rdata
    );

endinterface

// File: rtl/cpu_load_ctrl_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cpu_load_ctrl.sv
// Pin-driven program/data loader and run controller: assembles multi-byte words,
// writes and reads back the CPU memories, and owns the CPU run enable.
module cpu_load_ctrl
    import cpu_tt_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int INSTR_BYTES = 2,
    parameter int DATA_BYTES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            pin_data_i,
    input  logic [1:0]            pin_cmd_i,
    input  logic                  pin_is_instr_i,
    input  logic                  pin_strobe_i,
    cpu_load_ctrl_if.master       mem,
    output logic [7:0]            rd_byte_o,
    output logic                  rd_valid_o,
    output logic                  cpu_run_o,
    output logic [2:0]            err_o,
    output state_t                state_o
);

    localparam int         WORD_W = MAX_BYTES * 8;
    localparam logic [1:0] I_LAST = last_idx(INSTR_BYTES);
    localparam logic [1:0] D_LAST = last_idx(DATA_BYTES);

    logic              edge_s;
    cmd_t              cmd;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        wr_cnt_q;
    logic              wr_instr_q;
    logic [WORD_W-1:0] word_q;
    logic [1:0]        rd_idx_q;
    logic              rd_instr_q;
    logic [7:0]        rd_byte_q;
    logic              rd_valid_q;
    logic              run_q;
    logic [2:0]        err_q, err_d;
    logic              imem_we_q, dmem_we_q, mem_re_q;

    logic              accept;
    logic              wr_fresh, wr_last, rd_last, err_clr;
    logic [1:0]        wr_idx;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [7:0]        rd_sel;
    logic [2:0]        err_set;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_strobe (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pin_strobe_i),
        .rise_o  (edge_s)
    );

    assign cmd = cmd_t'(pin_cmd_i);

    always_comb begin
        accept   = edge_s && (state_q == IDLE) && (!run_q || cmd == CMD_CTRL);
        // A type change mid-word restarts assembly at byte 0 of the new type.
        wr_fresh = (wr_cnt_q == 2'd0) || (pin_is_instr_i != wr_instr_q);
        wr_idx   = wr_fresh ? 2'd0 : wr_cnt_q;
        wr_last  = (wr_idx == (pin_is_instr_i ? I_LAST : D_LAST));
        wr_word  = wr_fresh ? '0 : word_q;
        wr_word[{wr_idx, 3'b000} +: 8] = pin_data_i;

        rd_last = (rd_idx_q >= (rd_instr_q ? I_LAST : D_LAST));
        rd_word = rd_instr_q ? WORD_W'(mem.imem_rdata) : WORD_W'(mem.dmem_rdata);
        rd_sel  = rd_word[{rd_idx_q, 3'b000} +: 8];

        err_set = '0;
        if (edge_s) begin
            if (state_q != IDLE)
                err_set[ERR_OVERRUN] = 1'b1;
            else if (run_q && cmd != CMD_CTRL)
                err_set[ERR_RUNNING] = 1'b1;
            else if (cmd == CMD_WRITE && wr_cnt_q != 2'd0 && pin_is_instr_i != wr_instr_q)
                err_set[ERR_TYPE] = 1'b1;
        end
        err_clr = accept && (cmd == CMD_CTRL) && pin_data_i[7];
        err_d   = (err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_cnt_q   <= '0;
            wr_instr_q <= 1'b0;
            word_q     <= '0;
            rd_idx_q   <= '0;
            rd_instr_q <= 1'b0;
            rd_byte_q  <= '0;
            rd_valid_q <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= '0;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            mem_re_q   <= 1'b0;
        end else begin
            err_q     <= err_d;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            mem_re_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_SET_ADDR: begin
                                addr_q     <= pin_data_i[ADDR_W-1:0];
                                wr_cnt_q   <= '0;
                                rd_idx_q   <= '0;
                                rd_valid_q <= 1'b0;
                            end
                            CMD_WRITE: begin
                                rd_valid_q <= 1'b0;
                                word_q     <= wr_word;
                                wr_instr_q <= pin_is_instr_i;
                                if (wr_last) begin
                                    state_q   <= COMMIT;
                                    imem_we_q <= pin_is_instr_i;
                                    dmem_we_q <= !pin_is_instr_i;
                                end else begin
                                    wr_cnt_q <= wr_idx + 2'd1;
                                end
                            end
                            CMD_READ: begin
                                state_q    <= RD_WAIT;
                                mem_re_q   <= 1'b1;
                                rd_instr_q <= pin_is_instr_i;
                            end
                            default: begin
                                rd_valid_q <= 1'b0;
                                run_q      <= pin_data_i[0];
                                // Starting the CPU throws away any half-loaded word.
                                if (!run_q && pin_data_i[0])
                                    wr_cnt_q <= '0;
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    addr_q   <= addr_q + 1'b1;
                    wr_cnt_q <= '0;
                    state_q  <= IDLE;
                end
                RD_WAIT: state_q <= RD_CAP;
                RD_CAP: begin
                    rd_byte_q  <= rd_sel;
                    rd_valid_q <= 1'b1;
                    if (rd_last) begin
                        rd_idx_q <= '0;
                        addr_q   <= addr_q + 1'b1;
                    end else begin
                        rd_idx_q <= rd_idx_q + 2'd1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.imem_we      = imem_we_q;
    assign mem.imem_wdata   = word_q[INSTR_BYTES*8-1:0];
    assign mem.dmem_we      = dmem_we_q;
    assign mem.dmem_wdata   = word_q[DATA_BYTES*8-1:0];
    assign mem.mem_addr     = addr_q;
    assign mem.mem_re       = mem_re_q;
    assign mem.mem_re_instr = rd_instr_q;

    assign rd_byte_o  = rd_byte_q;
    assign rd_valid_o = rd_valid_q;
    assign cpu_run_o  = run_q;
    assign err_o      = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_load_ctrl.sv
// Directed bench for cpu_load_ctrl with a memory model and expected-event queues.
module tb_cpu_load_ctrl;
    import cpu_tt_pkg::*;

    localparam int ADDR_W = 5;
    localparam int IB     = 2;
    localparam int DB     = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pin_data = '0;
    logic [1:0] pin_cmd = '0;
    logic       pin_is_instr = 1'b0;
    logic       pin_strobe = 1'b0;
    logic [7:0] rd_byte;
    logic       rd_valid, cpu_run;
    logic [2:0] err;
    state_t     dbg_state;

    cpu_load_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB), .DATA_BYTES(DB)) mem_if ();

    cpu_load_ctrl #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB), .DATA_BYTES(DB), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pin_data_i     (pin_data),
        .pin_cmd_i      (pin_cmd),
        .pin_is_instr_i (pin_is_instr),
        .pin_strobe_i   (pin_strobe),
        .mem            (mem_if.master),
        .rd_byte_o      (rd_byte),
        .rd_valid_o     (rd_valid),
        .cpu_run_o      (cpu_run),
        .err_o          (err),
        .state_o        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [40:0] exp_q[$];     // {is_instr, addr, word}
    logic [8:0]  exp_re_q[$];  // {is_instr, addr}
    logic [7:0]  exp_rd_q[$];
    logic [15:0] imem_m [32];
    logic [7:0]  dmem_m [32];
    int          rd_pend = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                imem_m[i] <= '0;
                dmem_m[i] <= '0;
            end
            imem_m[5] <= 16'hBEEF;
            mem_if.imem_rdata <= '0;
            mem_if.dmem_rdata <= '0;
        end else begin
            if (mem_if.imem_we) imem_m[mem_if.mem_addr] <= mem_if.imem_wdata;
            if (mem_if.dmem_we) dmem_m[mem_if.mem_addr] <= mem_if.dmem_wdata;
            if (mem_if.mem_re) begin
                mem_if.imem_rdata <= imem_m[mem_if.mem_addr];
                mem_if.dmem_rdata <= dmem_m[mem_if.mem_addr];
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pend = 0;
        end else begin
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    if (exp_rd_q.size() == 0)
                        chk("rd_expected", 64'(exp_rd_q.size()), 64'd1);
                    else begin
                        chk("rd_byte", 64'(rd_byte), 64'(exp_rd_q.pop_front()));
                        chk("rd_valid", 64'(rd_valid), 64'd1);
                    end
                end
            end
            if (mem_if.imem_we || mem_if.dmem_we) begin
                if (exp_q.size() == 0)
                    chk("wr_expected", 64'(exp_q.size()), 64'd1);
                else
                    chk("wr_event",
                        64'({mem_if.imem_we, 8'(mem_if.mem_addr),
                             (mem_if.imem_we ? 32'(mem_if.imem_wdata) : 32'(mem_if.dmem_wdata))}),
                        64'(exp_q.pop_front()));
            end
            if (mem_if.mem_re) begin
                if (exp_re_q.size() == 0)
                    chk("re_expected", 64'(exp_re_q.size()), 64'd1);
                else
                    chk("re_event", 64'({mem_if.mem_re_instr, 8'(mem_if.mem_addr)}),
                        64'(exp_re_q.pop_front()));
                rd_pend = 2;
            end
        end
    end

    // ---------------- driver ----------------
    // lat = negedges after the strobe rises until the first memory pulse, -1 if none.
    task automatic send_cmd(input logic [1:0] c, input logic ins, input logic [7:0] d,
                            output int lat);
        @(negedge clk);
        pin_cmd      = c;
        pin_is_instr = ins;
        pin_data     = d;
        pin_strobe   = 1'b1;
        lat          = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (lat < 0 && (mem_if.imem_we || mem_if.dmem_we || mem_if.mem_re)) lat = i;
        end
        pin_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_we"}, 64'(mem_if.imem_we), 64'd0);
        chk({tag, "_dmem_we"}, 64'(mem_if.dmem_we), 64'd0);
        chk({tag, "_mem_re"}, 64'(mem_if.mem_re), 64'd0);
        chk({tag, "_re_instr"}, 64'(mem_if.mem_re_instr), 64'd0);
        chk({tag, "_addr"}, 64'(mem_if.mem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(mem_if.imem_wdata), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_byte"}, 64'(rd_byte), 64'd0);
        chk({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   lat;
        logic seen;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two-byte instruction write with address increment
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h03, lat);
        send_cmd(CMD_WRITE, 1'b1, 8'h34, lat);
        chk("t1_no_we_first_byte", 64'(lat), 64'(-1));
        exp_q.push_back({1'b1, 8'h03, 32'h1234});
        send_cmd(CMD_WRITE, 1'b1, 8'h12, lat);
        chk("t1_we_latency", 64'(lat), 64'd3);
        chk("t1_addr_after", 64'(mem_if.mem_addr), 64'd4);

        // data write at the top address wraps to 0
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h1F, lat);
        exp_q.push_back({1'b0, 8'h1F, 32'h00AA});
        send_cmd(CMD_WRITE, 1'b0, 8'hAA, lat);
        chk("t2_we_latency", 64'(lat), 64'd3);
        chk("t2_addr_wrap", 64'(mem_if.mem_addr), 64'd0);

        // little-endian readback of a preloaded instruction
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h05, lat);
        exp_re_q.push_back({1'b1, 8'h05});
        exp_rd_q.push_back(8'hEF);
        send_cmd(CMD_READ, 1'b1, 8'h00, lat);
        chk("t3_re_latency0", 64'(lat), 64'd3);
        chk("t3_addr_mid", 64'(mem_if.mem_addr), 64'd5);
        exp_re_q.push_back({1'b1, 8'h05});
        exp_rd_q.push_back(8'hBE);
        send_cmd(CMD_READ, 1'b1, 8'h00, lat);
        chk("t3_re_latency1", 64'(lat), 64'd3);
        chk("t3_addr_after", 64'(mem_if.mem_addr), 64'd6);
        chk("t3_rd_valid", 64'(rd_valid), 64'd1);

        // accesses while running are dropped
        send_cmd(CMD_CTRL, 1'b0, 8'h01, lat);
        chk("t4_run", 64'(cpu_run), 64'd1);
        chk("t4_rd_valid_cleared", 64'(rd_valid), 64'd0);
        send_cmd(CMD_WRITE, 1'b0, 8'h55, lat);
        chk("t4_no_we", 64'(lat), 64'(-1));
        chk("t4_err_running", 64'(err), 64'b010);
        send_cmd(CMD_READ, 1'b1, 8'h00, lat);
        chk("t4_no_re", 64'(lat), 64'(-1));
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h10, lat);
        chk("t4_addr_kept", 64'(mem_if.mem_addr), 64'd6);
        send_cmd(CMD_CTRL, 1'b0, 8'h80, lat);
        chk("t4_err_cleared", 64'(err), 64'd0);
        chk("t4_halted", 64'(cpu_run), 64'd0);

        // type switch mid-word
        send_cmd(CMD_WRITE, 1'b1, 8'h11, lat);
        chk("t5_no_we_partial", 64'(lat), 64'(-1));
        exp_q.push_back({1'b0, 8'h06, 32'h0022});
        send_cmd(CMD_WRITE, 1'b0, 8'h22, lat);
        chk("t5_dmem_latency", 64'(lat), 64'd3);
        chk("t5_err_type", 64'(err), 64'b100);
        chk("t5_addr_after", 64'(mem_if.mem_addr), 64'd7);

        // partial word survives CTRL but not a run start
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h08, lat);
        send_cmd(CMD_WRITE, 1'b1, 8'h78, lat);
        send_cmd(CMD_CTRL, 1'b0, 8'h00, lat);
        exp_q.push_back({1'b1, 8'h08, 32'h5678});
        send_cmd(CMD_WRITE, 1'b1, 8'h56, lat);
        chk("t7_survive_latency", 64'(lat), 64'd3);
        send_cmd(CMD_WRITE, 1'b1, 8'h9A, lat);
        send_cmd(CMD_CTRL, 1'b0, 8'h01, lat);
        send_cmd(CMD_CTRL, 1'b0, 8'h00, lat);
        send_cmd(CMD_WRITE, 1'b1, 8'hBC, lat);
        chk("t7_discarded_no_we", 64'(lat), 64'(-1));
        exp_q.push_back({1'b1, 8'h09, 32'hDEBC});
        send_cmd(CMD_WRITE, 1'b1, 8'hDE, lat);
        chk("t7_addr_after", 64'(mem_if.mem_addr), 64'd10);

        // read back earlier writes
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h03, lat);
        exp_re_q.push_back({1'b1, 8'h03});
        exp_rd_q.push_back(8'h34);
        send_cmd(CMD_READ, 1'b1, 8'h00, lat);
        exp_re_q.push_back({1'b1, 8'h03});
        exp_rd_q.push_back(8'h12);
        send_cmd(CMD_READ, 1'b1, 8'h00, lat);
        chk("t8_addr_after_instr", 64'(mem_if.mem_addr), 64'd4);
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h06, lat);
        exp_re_q.push_back({1'b0, 8'h06});
        exp_rd_q.push_back(8'h22);
        send_cmd(CMD_READ, 1'b0, 8'h00, lat);
        chk("t8_addr_after_data", 64'(mem_if.mem_addr), 64'd7);

        // second edge lands in RD_CAP: overrun, SET_ADDR dropped
        send_cmd(CMD_CTRL, 1'b0, 8'h80, lat);
        chk("t6_err_pre", 64'(err), 64'd0);
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h1F, lat);
        exp_re_q.push_back({1'b0, 8'h1F});
        exp_rd_q.push_back(8'hAA);
        @(negedge clk);
        pin_cmd = CMD_READ; pin_is_instr = 1'b0; pin_data = 8'h00; pin_strobe = 1'b1;
        @(negedge clk);
        pin_strobe = 1'b0;
        @(negedge clk);
        pin_strobe = 1'b1;
        @(negedge clk);
        pin_cmd = CMD_SET_ADDR; pin_data = 8'h02;
        repeat (6) @(negedge clk);
        pin_strobe = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_err_overrun", 64'(err), 64'b001);
        chk("t6_addr_not_set", 64'(mem_if.mem_addr), 64'd0);

        // reset while the read is in flight
        send_cmd(CMD_SET_ADDR, 1'b0, 8'h04, lat);
        exp_re_q.push_back({1'b1, 8'h04});
        @(negedge clk);
        pin_cmd = CMD_READ; pin_is_instr = 1'b1; pin_data = 8'h00; pin_strobe = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (mem_if.mem_re) seen = 1'b1;
        end
        chk("t6_re_seen", 64'(seen), 64'd1);
        #1;
        chk("t6_in_rd_wait", 64'(dbg_state), 64'(RD_WAIT));
        rst_n = 1'b0;
        pin_strobe = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_rd_valid_stays", 64'(rd_valid), 64'd0);
        chk("t6_state_idle", 64'(dbg_state), 64'(IDLE));

        chk("end_wr_queue", 64'(exp_q.size()), 64'd0);
        chk("end_re_queue", 64'(exp_re_q.size()), 64'd0);
        chk("end_rd_queue", 64'(exp_rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
